// File: rtl/ssd_scan_controller_if.sv
// Display-side bundle for ssd_scan_controller: digit/dp data and load in, anode/cathode drive out.
// brightness exists only when SSD_BRIGHTNESS_EN is defined.
interface ssd_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    blank_lz;
`ifdef SSD_BRIGHTNESS_EN
  logic [3:0]              brightness;
`endif
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [2:0]              digit_idx;

`ifdef SSD_BRIGHTNESS_EN
  modport master (output digits, dp, load, blank_lz, brightness,
                  input  an, seg, dp_n, digit_idx);
  modport slave  (input  digits, dp, load, blank_lz, brightness,
                  output an, seg, dp_n, digit_idx);
`else
  modport master (output digits, dp, load, blank_lz,
                  input  an, seg, dp_n, digit_idx);
  modport slave  (input  digits, dp, load, blank_lz,
                  output an, seg, dp_n, digit_idx);
`endif
endinterface

// File: rtl/ssd_scan_controller.sv
// Multiplexed 7-segment scan controller; an/seg/dp_n registered, 1 clk after digit_idx/shadow state.
// No backpressure. Define SSD_BRIGHTNESS_EN to add 4-bit anode PWM (brightness input).
module ssd_scan_controller #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV_BITS = 18
) (
  input logic                    clk,
  input logic                    reset,
  ssd_scan_controller_if.slave   bus
);
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] prescaler;
  logic                     tick;
  logic [2:0]               digit_idx;
  logic [4*NUM_DIGITS-1:0]  shadow_digits;
  logic [NUM_DIGITS-1:0]    shadow_dp;

  logic [31:0] digits_pad;
  logic [7:0]  dp_pad;
  logic [7:0]  zero_from;
  logic        zero_run;
  logic [3:0]  nibble;
  logic        blank;
  logic [7:0]  an_sel;
  logic        an_en;

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_n_q;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick = &prescaler;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler     <= '0;
      digit_idx     <= 3'd0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
      if (tick)
        digit_idx <= (digit_idx == LAST_IDX) ? 3'd0 : digit_idx + 3'd1;
      if (bus.load) begin
        shadow_digits <= bus.digits;
        shadow_dp     <= bus.dp;
      end
    end
  end

  // Pad to the 8-digit maximum so digit_idx indexes without width games.
  always_comb begin
    digits_pad = 32'(shadow_digits);
    dp_pad     = 8'(shadow_dp);
    nibble     = digits_pad[{digit_idx, 2'b00} +: 4];
    zero_run   = 1'b1;
    zero_from  = '0;
    for (int i = 7; i >= 0; i--) begin
      zero_run     = zero_run && (digits_pad[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
    blank  = bus.blank_lz && (digit_idx != 3'd0) && zero_from[digit_idx];
    an_sel = ~(8'd1 << digit_idx);
`ifdef SSD_BRIGHTNESS_EN
    an_en  = (prescaler[3:0] <= bus.brightness);
`else
    an_en  = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= '1;
      seg_q  <= 7'b1111111;
      dp_n_q <= 1'b1;
    end else begin
      an_q   <= an_en ? an_sel[NUM_DIGITS-1:0] : '1;
      seg_q  <= blank ? 7'b1111111 : decode(nibble);
      dp_n_q <= ~dp_pad[digit_idx];
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp_n      = dp_n_q;
  assign bus.digit_idx = digit_idx;
endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller: 4-digit instance checked every cycle against a time-based model,
// plus a 1-digit instance and hand-computed literal expectations.
module tb_ssd_scan_controller;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   chk_en;

  ssd_scan_controller_if #(.NUM_DIGITS(4)) if4 ();
  ssd_scan_controller_if #(.NUM_DIGITS(1)) if1 ();

  ssd_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV_BITS(4)) u4 (
    .clk(clk), .reset(reset), .bus(if4)
  );
  ssd_scan_controller #(.NUM_DIGITS(1), .SCAN_DIV_BITS(4)) u1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16];
  initial begin
    seg_tbl[0]  = 7'b0000001; seg_tbl[1]  = 7'b1001111;
    seg_tbl[2]  = 7'b0010010; seg_tbl[3]  = 7'b0000110;
    seg_tbl[4]  = 7'b1001100; seg_tbl[5]  = 7'b0100100;
    seg_tbl[6]  = 7'b0100000; seg_tbl[7]  = 7'b0001111;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0000100;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b1100000;
    seg_tbl[12] = 7'b0110001; seg_tbl[13] = 7'b1000010;
    seg_tbl[14] = 7'b0110000; seg_tbl[15] = 7'b0111000;
  end

  // Model: the scan position is just (clocks since reset)/16 mod 4.
  int         m_cyc;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp_n;
  logic [2:0]  exp_idx;

  always @(posedge clk) begin : model
    int idx;
    idx = (m_cyc / 16) % 4;
    if (reset) begin
      exp_an   = 4'b1111;
      exp_seg  = 7'b1111111;
      exp_dp_n = 1'b1;
    end else begin
      exp_an = ~(4'b0001 << idx);
`ifdef SSD_BRIGHTNESS_EN
      if ((m_cyc % 16) > int'(if4.brightness)) exp_an = 4'b1111;
`endif
      if (if4.blank_lz && idx > 0 && (m_dig >> (4 * idx)) == 16'd0)
        exp_seg = 7'b1111111;
      else
        exp_seg = seg_tbl[m_dig[4*idx +: 4]];
      exp_dp_n = ~m_dp[idx];
    end
    if (reset) begin
      m_cyc = 0;
      m_dig = 16'd0;
      m_dp  = 4'd0;
    end else begin
      if (if4.load) begin
        m_dig = if4.digits;
        m_dp  = if4.dp;
      end
      m_cyc++;
    end
    exp_idx = 3'((m_cyc / 16) % 4);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_an",   32'(if4.an),        32'(exp_an));
      chk("cyc_seg",  32'(if4.seg),       32'(exp_seg));
      chk("cyc_dp_n", 32'(if4.dp_n),      32'(exp_dp_n));
      chk("cyc_idx",  32'(if4.digit_idx), 32'(exp_idx));
    end
  end

  task automatic wait_an(input logic [3:0] pat);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if4.an == pat) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_an actual=%b required=%b", if4.an, pat);
    end
  endtask

  task automatic wait_idx(input logic [2:0] target, input bool_last);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if4.digit_idx == target && (!bool_last || (m_cyc % 16) == 15)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_idx actual=%0d required=%0d", if4.digit_idx, target);
    end
  endtask

  task automatic chk_u1(input string name);
    chk({name, "_u1_an"},  32'(if1.an),        32'h0);
    chk({name, "_u1_seg"}, 32'(if1.seg),       32'(7'b0111000));
    chk({name, "_u1_idx"}, 32'(if1.digit_idx), 32'h0);
  endtask

  logic [3:0] pats [4];
  logic [6:0] segs [4];

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0;
    reset = 1'b1;
    if4.digits = 16'h0; if4.dp = 4'h0; if4.load = 1'b0; if4.blank_lz = 1'b0;
    if1.digits = 4'h0;  if1.dp = 1'b0; if1.load = 1'b0; if1.blank_lz = 1'b0;
`ifdef SSD_BRIGHTNESS_EN
    if4.brightness = 4'd15; if1.brightness = 4'd15;
`endif
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_an",     32'(if4.an),        32'hF);
    chk("rst_seg",    32'(if4.seg),       32'h7F);
    chk("rst_dp_n",   32'(if4.dp_n),      32'h1);
    chk("rst_idx",    32'(if4.digit_idx), 32'h0);
    chk("rst_u1_an",  32'(if1.an),        32'h1);
    chk("rst_u1_seg", 32'(if1.seg),       32'h7F);

    reset = 1'b0;
    @(negedge clk);
    chk("first_an",   32'(if4.an),   32'(4'b1110));
    chk("first_seg",  32'(if4.seg),  32'(7'b0000001));
    chk("first_dp_n", 32'(if4.dp_n), 32'h1);

    if4.digits = 16'h1234; if4.dp = 4'b0000; if4.load = 1'b1;
    if1.digits = 4'hF; if1.load = 1'b1;
    @(negedge clk);
    if4.load = 1'b0; if1.load = 1'b0;
    @(negedge clk);
    pats[0] = 4'b1101; segs[0] = 7'b0000110;
    pats[1] = 4'b1011; segs[1] = 7'b0010010;
    pats[2] = 4'b0111; segs[2] = 7'b1001111;
    pats[3] = 4'b1110; segs[3] = 7'b1001100;
    for (int k = 0; k < 4; k++) begin
      wait_an(pats[k]);
      chk("scan1234_seg", 32'(if4.seg), 32'(segs[k]));
    end
    chk_u1("after_load");

    // Input change without load must not reach the display.
    if4.digits = 16'h9999;
    repeat (20) @(negedge clk);
    wait_an(4'b1110);
    chk("noload_seg", 32'(if4.seg), 32'(7'b1001100));

    // Load coinciding with the 0->1 tick.
    wait_idx(3'd0, 1'b1);
    if4.digits = 16'h0070; if4.load = 1'b1; if4.blank_lz = 1'b1;
    @(negedge clk);
    if4.load = 1'b0;
    @(negedge clk);
    chk("tickload_an",  32'(if4.an),  32'(4'b1101));
    chk("tickload_seg", 32'(if4.seg), 32'(7'b0001111));
    wait_an(4'b1011);
    chk("blank_d2", 32'(if4.seg), 32'h7F);
    wait_an(4'b0111);
    chk("blank_d3", 32'(if4.seg), 32'h7F);
    wait_an(4'b1110);
    chk("blank_d0", 32'(if4.seg), 32'(7'b0000001));
    if4.blank_lz = 1'b0;
    wait_an(4'b1011);
    chk("noblank_d2", 32'(if4.seg), 32'(7'b0000001));
    wait_an(4'b0111);
    chk("noblank_d3", 32'(if4.seg), 32'(7'b0000001));

    if4.dp = 4'b0100; if4.load = 1'b1;
    @(negedge clk);
    if4.load = 1'b0;
    wait_an(4'b1011);
    chk("dp_d2", 32'(if4.dp_n), 32'h0);
    wait_an(4'b1110);
    chk("dp_d0", 32'(if4.dp_n), 32'h1);

    // Reset in the middle of digit 2.
    wait_idx(3'd2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_an",  32'(if4.an),        32'hF);
    chk("midrst_seg", 32'(if4.seg),       32'h7F);
    chk("midrst_idx", 32'(if4.digit_idx), 32'h0);
    reset = 1'b0;
    if1.load = 1'b1;
    @(negedge clk);
    if1.load = 1'b0;
    repeat (40) @(negedge clk);
    chk_u1("end");

`ifdef SSD_BRIGHTNESS_EN
    begin
      int lit;
      if4.brightness = 4'd3;
      repeat (20) @(negedge clk);
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (if4.an != 4'hF) lit++;
      end
      chk("bright3_low", 32'(lit), 32'd4);
      if4.brightness = 4'd15;
      repeat (4) @(negedge clk);
      lit = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (if4.an != 4'hF) lit++;
      end
      chk("bright15_low", 32'(lit), 32'd16);
    end
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
